// File: rtl/parking_gate_arbiter.sv
// Shared entry/exit barrier arbiter with occupancy tracking and auth/open-window timeouts.
// Define PARK_EXIT_PRIO_EN for fixed exit-over-entry priority instead of round-robin.
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned AUTH_CYCLES = 32,
  parameter int unsigned OPEN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ent_req,
  input  logic             exit_req,
  input  logic             auth_ok,
  input  logic             gate_pass,
  output logic             ent_grant,
  output logic             exit_grant,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             timeout
);

  localparam int unsigned MaxCycles = (AUTH_CYCLES > OPEN_CYCLES) ? AUTH_CYCLES : OPEN_CYCLES;
  localparam int unsigned TmrW      = $clog2(MaxCycles) + 1;

  localparam logic [CNT_W-1:0] Cap      = CNT_W'(CAPACITY);
  localparam logic [TmrW-1:0]  AuthLast = TmrW'(AUTH_CYCLES - 1);
  localparam logic [TmrW-1:0]  OpenLast = TmrW'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StEntAuth, StEntOpen, StExitOpen} state_e;

  state_e          state_q;
  logic [TmrW-1:0] timer_q;
  logic            ent_ok;
  logic            exit_ok;
  logic            ent_wins;

  assign ent_ok  = ent_req & ~full;
  assign exit_ok = exit_req & ~empty;

`ifdef PARK_EXIT_PRIO_EN
  assign ent_wins = ent_ok & ~exit_ok;
`else
  logic last_exit_q;  // last_served == EXIT, so entrance wins the next tie
  assign ent_wins = ent_ok & (~exit_ok | last_exit_q);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      occupancy  <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      ent_grant  <= 1'b0;
      exit_grant <= 1'b0;
      gate_open  <= 1'b0;
      timeout    <= 1'b0;
`ifndef PARK_EXIT_PRIO_EN
      last_exit_q <= 1'b1;
`endif
    end else begin
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (ent_wins) begin
            state_q   <= StEntAuth;
            ent_grant <= 1'b1;
`ifndef PARK_EXIT_PRIO_EN
            last_exit_q <= 1'b0;
`endif
          end else if (exit_ok) begin
            state_q    <= StExitOpen;
            exit_grant <= 1'b1;
            gate_open  <= 1'b1;
`ifndef PARK_EXIT_PRIO_EN
            last_exit_q <= 1'b1;
`endif
          end
        end
        StEntAuth: begin
          if (auth_ok) begin
            state_q   <= StEntOpen;
            gate_open <= 1'b1;
            timer_q   <= '0;
          end else if (!ent_req || timer_q == AuthLast) begin
            // A vehicle that backs away is not a timeout.
            state_q   <= StIdle;
            ent_grant <= 1'b0;
            timer_q   <= '0;
            timeout   <= ent_req;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StEntOpen, StExitOpen: begin
          if (gate_pass || timer_q == OpenLast) begin
            state_q    <= StIdle;
            ent_grant  <= 1'b0;
            exit_grant <= 1'b0;
            gate_open  <= 1'b0;
            timer_q    <= '0;
            timeout    <= ~gate_pass;
            if (gate_pass) begin
              // Saturating guards kept even though full/empty already gate the grants.
              if (state_q == StEntOpen) begin
                if (occupancy < Cap) begin
                  occupancy <= occupancy + 1'b1;
                  full      <= (occupancy + 1'b1 == Cap);
                  empty     <= 1'b0;
                end
              end else if (occupancy != '0) begin
                occupancy <= occupancy - 1'b1;
                full      <= 1'b0;
                empty     <= (occupancy == CNT_W'(1));
              end
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the lot and gate.
module tb_parking_gate_arbiter;

  localparam int Cap  = 8;
  localparam int Auth = 32;
  localparam int Open = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ent_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       auth_ok = 1'b0;
  logic       gate_pass = 1'b0;
  logic       ent_grant;
  logic       exit_grant;
  logic       gate_open;
  logic [3:0] occupancy;
  logic       full;
  logic       empty;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model: who owns the gate (0 none, 1 entrance, 2 exit), whether the barrier is up,
  // how many cycles the current phase has lasted, and the vehicle count.
  int m_owner    = 0;
  bit m_opened   = 1'b0;
  int m_elapsed  = 0;
  int m_occ      = 0;
  bit m_last_ent = 1'b0;
  bit m_timeout  = 1'b0;

  parking_gate_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .ent_req   (ent_req),
    .exit_req  (exit_req),
    .auth_ok   (auth_ok),
    .gate_pass (gate_pass),
    .ent_grant (ent_grant),
    .exit_grant(exit_grant),
    .gate_open (gate_open),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_opened   = 1'b0;
    m_elapsed  = 0;
    m_occ      = 0;
    m_last_ent = 1'b0;
    m_timeout  = 1'b0;
  endtask

  task automatic model_step();
    bit e_ok, x_ok, pick_ent, pick_exit;
    m_timeout = 1'b0;
    if (m_owner == 0) begin
      e_ok = ent_req && (m_occ < Cap);
      x_ok = exit_req && (m_occ > 0);
`ifdef PARK_EXIT_PRIO_EN
      pick_exit = x_ok;
      pick_ent  = e_ok && !x_ok;
`else
      if (e_ok && x_ok) pick_ent = !m_last_ent;
      else pick_ent = e_ok;
      pick_exit = x_ok && !pick_ent;
`endif
      if (pick_ent) begin
        m_owner = 1; m_opened = 1'b0; m_elapsed = 0; m_last_ent = 1'b1;
      end else if (pick_exit) begin
        m_owner = 2; m_opened = 1'b1; m_elapsed = 0; m_last_ent = 1'b0;
      end
    end else if (!m_opened) begin
      if (auth_ok) begin
        m_opened = 1'b1; m_elapsed = 0;
      end else if (!ent_req) begin
        m_owner = 0;
      end else if (m_elapsed + 1 == Auth) begin
        m_owner = 0; m_timeout = 1'b1;
      end else begin
        m_elapsed++;
      end
    end else begin
      if (gate_pass) begin
        m_occ   = (m_owner == 1) ? m_occ + 1 : m_occ - 1;
        m_owner = 0;
      end else if (m_elapsed + 1 == Open) begin
        m_owner = 0; m_timeout = 1'b1;
      end else begin
        m_elapsed++;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ent_grant", ent_grant, (m_owner == 1) ? 1 : 0);
      chk("exit_grant", exit_grant, (m_owner == 2) ? 1 : 0);
      chk("gate_open", gate_open, (m_owner != 0 && m_opened) ? 1 : 0);
      chk("occupancy", occupancy, m_occ);
      chk("full", full, (m_occ == Cap) ? 1 : 0);
      chk("empty", empty, (m_occ == 0) ? 1 : 0);
      chk("timeout", timeout, m_timeout);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_entry();
    ent_req = 1'b1; cyc();
    auth_ok = 1'b1; cyc();
    auth_ok = 1'b0; ent_req = 1'b0; gate_pass = 1'b1; cyc();
    gate_pass = 1'b0; cyc();
  endtask

  task automatic do_exit();
    exit_req = 1'b1; cyc();
    exit_req = 1'b0; gate_pass = 1'b1; cyc();
    gate_pass = 1'b0; cyc();
  endtask

  initial begin
    int g, tc, oc;
    bit exp_ent;

    #2 reset = 1'b0;
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_grants", {ent_grant, exit_grant, gate_open, timeout}, 0);
    chk_en = 1'b1;
    cyc();
    #2 reset = 1'b1;

    // Basic entry with the latencies pinned by hand.
    ent_req = 1'b1; cyc();
    chk("req_to_grant", ent_grant, 1);
    chk("no_open_before_auth", gate_open, 0);
    cyc(); cyc();
    auth_ok = 1'b1; cyc();
    auth_ok = 1'b0;
    chk("auth_to_open", gate_open, 1);
    repeat (3) cyc();
    gate_pass = 1'b1; ent_req = 1'b0; cyc();
    gate_pass = 1'b0;
    chk("pass_occ", occupancy, 1);
    chk("pass_empty", empty, 0);
    chk("pass_gate_closed", gate_open, 0);
    cyc();

    // Fill the lot, then a held request must be refused.
    repeat (7) do_entry();
    chk("fill_occ", occupancy, 8);
    chk("fill_full", full, 1);
    ent_req = 1'b1; g = 0;
    repeat (50) begin cyc(); g += int'(ent_grant); end
    ent_req = 1'b0;
    chk("full_blocks_grant", g, 0);
    chk("full_occ_held", occupancy, 8);

    repeat (5) do_exit();
    chk("drain_occ", occupancy, 3);

    // Both lanes waiting; each grant is left to time out.
    ent_req = 1'b1; exit_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
`ifdef PARK_EXIT_PRIO_EN
      exp_ent = 1'b0;
`else
      exp_ent = (i % 2 == 0);
`endif
      chk("arb_ent", ent_grant, exp_ent);
      chk("arb_exit", exit_grant, !exp_ent);
      for (int k = 0; k < 40 && (ent_grant || exit_grant); k++) cyc();
      chk("arb_release", ent_grant | exit_grant, 0);
    end
    ent_req = 1'b0; exit_req = 1'b0; cyc();
    chk("arb_occ", occupancy, 3);

    // Auth timeout.
    ent_req = 1'b1; g = 0; tc = 0; oc = 0;
    repeat (33) begin
      cyc(); g += int'(ent_grant); tc += int'(timeout); oc += int'(gate_open);
    end
    ent_req = 1'b0; cyc();
    tc += int'(timeout); oc += int'(gate_open);
    chk("auth_grant_cycles", g, 32);
    chk("auth_timeout_pulses", tc, 1);
    chk("auth_gate_never_open", oc, 0);

    // Open-window timeout on exit.
    do_exit();
    chk("pre_open_to_occ", occupancy, 2);
    exit_req = 1'b1; cyc();
    exit_req = 1'b0; oc = int'(gate_open); tc = int'(timeout);
    repeat (17) begin cyc(); oc += int'(gate_open); tc += int'(timeout); end
    chk("open_cycles", oc, 16);
    chk("open_timeout_pulses", tc, 1);
    chk("open_to_occ", occupancy, 2);

    // Reset in the middle of an entry's open window.
    ent_req = 1'b1; cyc();
    auth_ok = 1'b1; cyc();
    auth_ok = 1'b0; ent_req = 1'b0; cyc();
    chk("mid_open_before_rst", gate_open, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_drops_gate", gate_open, 0);
    chk("rst_clears_occ", occupancy, 0);
    chk("rst_clears_grant", ent_grant, 0);
    cyc();
    #2 reset = 1'b1;
    gate_pass = 1'b1; cyc();
    gate_pass = 1'b0;
    chk("post_rst_pass_ignored", occupancy, 0);
    chk("post_rst_gate", gate_open, 0);
    chk("post_rst_empty", empty, 1);

    // Randomized traffic.
    repeat (4000) begin
      ent_req   = ($urandom_range(0, 99) < 60);
      exit_req  = ($urandom_range(0, 99) < 45);
      auth_ok   = ($urandom_range(0, 99) < 12);
      gate_pass = ($urandom_range(0, 99) < 15);
      cyc();
    end
    ent_req = 1'b0; exit_req = 1'b0; auth_ok = 1'b0; gate_pass = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
